commit_trace_fifo: RTL and testbench



---
 rtl/commit_trace_fifo_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 53 +++++
 rtl/commit_trace_fifo.sv | 100 ++++++++++
 tb/tb_commit_trace_fifo.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_fifo_pkg.sv
// Shared types for the commit-trace recorder: register-file aliases and the trace entry layout.
package commit_trace_fifo_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef logic        Bit_t;
  typedef logic [4:0]  Reg_addr_t;
  typedef logic [31:0] Reg_data_t;

  localparam int unsigned TRACE_DROP_W = 16;

  typedef enum logic [1:0] {
    TRACE_SKIP = 2'd0,
    TRACE_REG  = 2'd1,
    TRACE_HILO = 2'd2
  } Trace_kind_t;

  // 2 + 32 + 5 + 32 + 32 = 103 bits
  typedef struct packed {
    Trace_kind_t kind;
    Reg_data_t   cycle;
    Reg_addr_t   addr;
    Reg_data_t   data0;
    Reg_data_t   data1;
  } Trace_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; separate occupancy count disambiguates full from empty.
module sync_fifo #(
  parameter type         elem_t = logic [7:0],
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  elem_t            push_data,
  input  logic             pop,
  output elem_t            pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  elem_t            mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push, do_pop;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;

  // A pop frees a slot in the same edge, so push while full is accepted only alongside a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Empty FIFO presents all-zero data rather than a stale slot.
  assign pop_data = empty ? '0 : mem[rd_ptr_q];

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/commit_trace_fifo.sv
// Commit-trace recorder: classifies each enabled writeback cycle into a numbered entry and queues it.
module commit_trace_fifo
  import commit_trace_fifo_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter bit          RECORD_SKIP = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trace_en,
  input  logic                    reg_write_enable,
  input  logic [4:0]              reg_write_addr,
  input  logic [31:0]             reg_write_data,
  input  logic                    hilo_we,
  input  logic [31:0]             hi_data,
  input  logic [31:0]             lo_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [1:0]              rd_kind,
  output logic [31:0]             rd_cycle,
  output logic [4:0]              rd_addr,
  output logic [31:0]             rd_data0,
  output logic [31:0]             rd_data1,
  output logic [$clog2(DEPTH):0]  fill_count,
  output logic [15:0]             dropped_count,
  output logic                    overflow
);

  Reg_data_t                 cycle_q;
  logic [TRACE_DROP_W-1:0]   dropped_q;
  Bit_t                      overflow_q;
  Trace_entry_t              entry, head;
  Bit_t                      push, full, empty, drop, sampling;

  assign sampling = (trace_en == ENABLE);

  // Classify the current cycle: register write wins over HI/LO, otherwise SKIP.
  always_comb begin
    entry       = '0;
    entry.cycle = cycle_q + 32'd1;
    push        = DISABLE;
    if (reg_write_enable) begin
      entry.kind  = TRACE_REG;
      entry.addr  = reg_write_addr;
      entry.data0 = reg_write_data;
      push        = sampling;
    end else if (hilo_we) begin
      entry.kind  = TRACE_HILO;
      entry.data0 = hi_data;
      entry.data1 = lo_data;
      push        = sampling;
    end else begin
      entry.kind  = TRACE_SKIP;
      push        = sampling & RECORD_SKIP;
    end
  end

  // A push is lost only when full and the consumer is not taking the head this edge.
  assign drop = push & full & ~rd_ready;

  sync_fifo #(
    .elem_t (Trace_entry_t),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (entry),
    .pop       (rd_ready),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (fill_count)
  );

  // Cycle counter and drop accounting; counter advances even when the entry is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_q    <= '0;
      dropped_q  <= '0;
      overflow_q <= DISABLE;
    end else begin
      if (sampling) cycle_q <= cycle_q + 32'd1;
      if (drop) begin
        overflow_q <= ENABLE;
        if (dropped_q != '1) dropped_q <= dropped_q + TRACE_DROP_W'(1);
      end
    end
  end

  assign rd_valid      = ~empty;
  assign rd_kind       = head.kind;
  assign rd_cycle      = head.cycle;
  assign rd_addr       = head.addr;
  assign rd_data0      = head.data0;
  assign rd_data1      = head.data1;
  assign dropped_count = dropped_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Directed bench for commit_trace_fifo; a second instance covers RECORD_SKIP = 0.
module tb_commit_trace_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        trace_en, reg_write_enable, hilo_we, rd_ready;
  logic [4:0]  reg_write_addr;
  logic [31:0] reg_write_data, hi_data, lo_data;

  logic        rd_valid, overflow;
  logic [1:0]  rd_kind;
  logic [31:0] rd_cycle, rd_data0, rd_data1;
  logic [4:0]  rd_addr;
  logic [4:0]  fill_count;
  logic [15:0] dropped_count;

  logic        ns_valid, ns_overflow;
  logic [1:0]  ns_kind;
  logic [31:0] ns_cycle, ns_data0, ns_data1;
  logic [4:0]  ns_addr;
  logic [4:0]  ns_fill;
  logic [15:0] ns_dropped;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  commit_trace_fifo #(.DEPTH(16), .RECORD_SKIP(1'b1)) dut (
    .clk              (clk),
    .rst              (rst),
    .trace_en         (trace_en),
    .reg_write_enable (reg_write_enable),
    .reg_write_addr   (reg_write_addr),
    .reg_write_data   (reg_write_data),
    .hilo_we          (hilo_we),
    .hi_data          (hi_data),
    .lo_data          (lo_data),
    .rd_valid         (rd_valid),
    .rd_ready         (rd_ready),
    .rd_kind          (rd_kind),
    .rd_cycle         (rd_cycle),
    .rd_addr          (rd_addr),
    .rd_data0         (rd_data0),
    .rd_data1         (rd_data1),
    .fill_count       (fill_count),
    .dropped_count    (dropped_count),
    .overflow         (overflow)
  );

  commit_trace_fifo #(.DEPTH(16), .RECORD_SKIP(1'b0)) dut_ns (
    .clk              (clk),
    .rst              (rst),
    .trace_en         (trace_en),
    .reg_write_enable (reg_write_enable),
    .reg_write_addr   (reg_write_addr),
    .reg_write_data   (reg_write_data),
    .hilo_we          (hilo_we),
    .hi_data          (hi_data),
    .lo_data          (lo_data),
    .rd_valid         (ns_valid),
    .rd_ready         (rd_ready),
    .rd_kind          (ns_kind),
    .rd_cycle         (ns_cycle),
    .rd_addr          (ns_addr),
    .rd_data0         (ns_data0),
    .rd_data1         (ns_data1),
    .fill_count       (ns_fill),
    .dropped_count    (ns_dropped),
    .overflow         (ns_overflow)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_idle();
    reg_write_enable = 1'b0;
    reg_write_addr   = '0;
    reg_write_data   = '0;
    hilo_we          = 1'b0;
    hi_data          = '0;
    lo_data          = '0;
  endtask

  task automatic drive_reg(input logic [4:0] a, input logic [31:0] d);
    drive_idle();
    reg_write_enable = 1'b1;
    reg_write_addr   = a;
    reg_write_data   = d;
  endtask

  task automatic drive_hilo(input logic [31:0] h, input logic [31:0] l);
    drive_idle();
    hilo_we = 1'b1;
    hi_data = h;
    lo_data = l;
  endtask

  // Pulse reset across one clock edge, inputs changed only at falling edges.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    trace_en = 1'b0;
    rd_ready = 1'b0;
    drive_idle();

    // Reset values
    #2;
    check_eq("rst_valid", rd_valid, 0);
    check_eq("rst_fill", fill_count, 0);
    check_eq("rst_cycle", rd_cycle, 0);
    check_eq("rst_data0", rd_data0, 0);
    check_eq("rst_dropped", dropped_count, 0);
    check_eq("rst_overflow", overflow, 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic sequence: REG, idle, HILO, REG with consumer always ready
    trace_en = 1'b1;
    rd_ready = 1'b1;
    drive_reg(5'd1, 32'h0000_1234);
    @(negedge clk);
    check_eq("e1_valid", rd_valid, 1);
    check_eq("e1_kind", rd_kind, 1);
    check_eq("e1_cycle", rd_cycle, 1);
    check_eq("e1_addr", rd_addr, 1);
    check_eq("e1_data0", rd_data0, 32'h0000_1234);
    drive_idle();
    @(negedge clk);
    check_eq("e2_kind", rd_kind, 0);
    check_eq("e2_cycle", rd_cycle, 2);
    check_eq("e2_data0", rd_data0, 0);
    check_eq("e2_fill", fill_count, 1);
    drive_hilo(32'h1, 32'hFFFF_FFFE);
    @(negedge clk);
    check_eq("e3_kind", rd_kind, 2);
    check_eq("e3_cycle", rd_cycle, 3);
    check_eq("e3_addr", rd_addr, 0);
    check_eq("e3_hi", rd_data0, 32'h1);
    check_eq("e3_lo", rd_data1, 32'hFFFF_FFFE);
    drive_reg(5'd2, 32'hDEAD_BEEF);
    @(negedge clk);
    check_eq("e4_kind", rd_kind, 1);
    check_eq("e4_cycle", rd_cycle, 4);
    check_eq("e4_addr", rd_addr, 2);
    check_eq("e4_data0", rd_data0, 32'hDEAD_BEEF);
    trace_en = 1'b0;
    drive_idle();
    @(negedge clk);
    check_eq("drained_valid", rd_valid, 0);
    check_eq("drained_fill", fill_count, 0);

    // REG and HILO in the same cycle: REG wins, single entry
    trace_en = 1'b1;
    rd_ready = 1'b0;
    drive_reg(5'd3, 32'h5);
    hilo_we = 1'b1;
    hi_data = 32'h7;
    @(negedge clk);
    trace_en = 1'b0;
    drive_idle();
    check_eq("prio_fill", fill_count, 1);
    check_eq("prio_kind", rd_kind, 1);
    check_eq("prio_cycle", rd_cycle, 5);
    check_eq("prio_addr", rd_addr, 3);
    check_eq("prio_data0", rd_data0, 32'h5);
    check_eq("prio_data1", rd_data1, 0);
    rd_ready = 1'b1;
    @(negedge clk);
    check_eq("prio_empty", rd_valid, 0);

    // Fill past DEPTH with no consumer: 16 kept, 4 dropped
    rd_ready = 1'b0;
    do_reset();
    trace_en = 1'b1;
    repeat (20) @(negedge clk);
    check_eq("full_fill", fill_count, 16);
    check_eq("full_dropped", dropped_count, 4);
    check_eq("full_overflow", overflow, 1);
    check_eq("full_head_cycle", rd_cycle, 1);

    // Push with simultaneous pop while full is accepted
    drive_reg(5'd5, 32'hAA);
    rd_ready = 1'b1;
    @(negedge clk);
    trace_en = 1'b0;
    drive_idle();
    check_eq("pp_fill", fill_count, 16);
    check_eq("pp_dropped", dropped_count, 4);
    for (int i = 2; i <= 16; i++) begin
      check_eq($sformatf("drain_cycle_%0d", i), rd_cycle, 64'(i));
      @(negedge clk);
    end
    check_eq("pp_last_kind", rd_kind, 1);
    check_eq("pp_last_cycle", rd_cycle, 21);
    check_eq("pp_last_addr", rd_addr, 5);
    @(negedge clk);
    check_eq("pp_empty_valid", rd_valid, 0);
    check_eq("pp_empty_kind", rd_kind, 0);
    check_eq("pp_overflow_sticky", overflow, 1);

    // RECORD_SKIP = 0: idle cycles advance the counter but push nothing
    rd_ready = 1'b0;
    do_reset();
    trace_en = 1'b1;
    drive_reg(5'd7, 32'h11);
    @(negedge clk);
    drive_idle();
    repeat (2) @(negedge clk);
    drive_reg(5'd8, 32'h22);
    @(negedge clk);
    trace_en = 1'b0;
    drive_idle();
    check_eq("ns_fill", ns_fill, 2);
    check_eq("skip_fill", fill_count, 4);
    check_eq("ns_head_cycle", ns_cycle, 1);
    check_eq("ns_head_addr", ns_addr, 7);
    rd_ready = 1'b1;
    @(negedge clk);
    check_eq("ns_second_cycle", ns_cycle, 4);
    check_eq("ns_second_addr", ns_addr, 8);
    check_eq("ns_second_data", ns_data0, 32'h22);

    // Mid-operation reset discards queued entries immediately
    rd_ready = 1'b0;
    do_reset();
    trace_en = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("pre_rst_fill", fill_count, 5);
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", rd_valid, 0);
    check_eq("async_rst_fill", fill_count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_fill", fill_count, 1);
    check_eq("post_rst_cycle", rd_cycle, 1);
    check_eq("post_rst_dropped", dropped_count, 0);
    trace_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
